// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the GBA memory front end
// Purpose: access size, region codes (numerically equal to the addr[27:24] nibble),
//   region base addresses, arbiter FSM states and the region decoder.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    REGION_BIOS     = 3'd0,
    REGION_UNMAPPED = 3'd1,
    REGION_EWRAM    = 3'd2,
    REGION_IWRAM    = 3'd3,
    REGION_PALETTE  = 3'd5,
    REGION_VRAM     = 3'd6,
    REGION_OAM      = 3'd7
  } region_t;

  localparam logic [31:0] BASE_BIOS    = 32'h0000_0000;
  localparam logic [31:0] BASE_EWRAM   = 32'h0200_0000;
  localparam logic [31:0] BASE_IWRAM   = 32'h0300_0000;
  localparam logic [31:0] BASE_PALETTE = 32'h0500_0000;
  localparam logic [31:0] BASE_VRAM    = 32'h0600_0000;
  localparam logic [31:0] BASE_OAM     = 32'h0700_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  function automatic region_t decode_region(input logic [3:0] nib);
    case (nib)
      BASE_BIOS[27:24]:    decode_region = REGION_BIOS;
      BASE_EWRAM[27:24]:   decode_region = REGION_EWRAM;
      BASE_IWRAM[27:24]:   decode_region = REGION_IWRAM;
      BASE_PALETTE[27:24]: decode_region = REGION_PALETTE;
      BASE_VRAM[27:24]:    decode_region = REGION_VRAM;
      BASE_OAM[27:24]:     decode_region = REGION_OAM;
      default:             decode_region = REGION_UNMAPPED;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, write-data replication, read alignment
// Purpose: combinational lane logic for one access.
// Ports: size/addr_lo describe the access; wdata low-aligned write data;
//   rdata_raw bank word; byte_en lane enables; wdata_rep replicated write data;
//   rdata_out read data returned to the requester.
// Build option: MEM_ARB_READ_ALIGN_EN - rdata_out aligned per size; otherwise raw word.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_out
);

  always_comb begin
    byte_en   = 4'hF;
    wdata_rep = wdata;
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;  // word and reserved size 11 both access all four lanes
    endcase
  end

`ifdef MEM_ARB_READ_ALIGN_EN
  // Rotating right by 8*addr_lo brings the addressed byte lane to bits [7:0],
  // which also gives the ARM LDR result for misaligned word reads.
  logic [31:0] rot;
  always_comb begin
    case (addr_lo)
      2'd1:    rot = {rdata_raw[7:0],  rdata_raw[31:8]};
      2'd2:    rot = {rdata_raw[15:0], rdata_raw[31:16]};
      2'd3:    rot = {rdata_raw[23:0], rdata_raw[31:24]};
      default: rot = rdata_raw;
    endcase
    case (size)
      SIZE_BYTE: rdata_out = {24'h0, rot[7:0]};
      SIZE_HALF: rdata_out = {16'h0, (addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0])};
      default:   rdata_out = rot;
    endcase
  end
`else
  assign rdata_out = rdata_raw;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin N-port front end onto one shared memory bank port
// Purpose: grants requesters round-robin, decodes region from addr[27:24], inserts
//   per-region wait states and drives byte-lane write enables onto the bank port.
// Ports: clock; reset (asynchronous, active-high); req_valid/req_addr/req_wdata/
//   req_size/req_write flat per-port request buses; pause per-port stall; rdata read
//   result (valid while the granted port's pause is low); mem_en/mem_we/mem_region/
//   mem_addr/mem_wdata bank access; mem_rdata bank data one cycle after mem_en.
// Build option: MEM_ARB_READ_ALIGN_EN (read alignment, see mem_lane_align).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int          NUM_PORTS   = 3,
  parameter logic [31:0] WAIT_STATES = 32'h0000_0200,  // 4b per region code; EWRAM = 2
  parameter int          ADDR_W      = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0]     req_wdata,
  input  logic [NUM_PORTS*2-1:0]      req_size,
  input  logic [NUM_PORTS-1:0]        req_write,
  output logic [NUM_PORTS-1:0]        pause,
  output logic [31:0]                 rdata,
  output logic                        mem_en,
  output logic [3:0]                  mem_we,
  output logic [2:0]                  mem_region,
  output logic [23:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  mem_size_t         size_q, size_d;
  logic              write_q, write_d;
  logic [3:0]        wait_q, wait_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [31:0]       wdata_arr [NUM_PORTS];
  logic [1:0]        size_arr  [NUM_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_arr[i]  = req_addr[ADDR_W*i +: ADDR_W];
      wdata_arr[i] = req_wdata[32*i +: 32];
      size_arr[i]  = req_size[2*i +: 2];
    end
  end

  // First valid port at or after rr_ptr: scan from the far end so the nearest wins.
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;
  int               cand;
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (req_valid[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  region_t     region;
  logic [3:0]  ws;
  logic [3:0]  lane_be;
  logic [31:0] rd_aligned;
  logic [31:0] rd_now;
  logic        unused_addr_hi;

  assign region         = decode_region(addr_q[27:24]);
  assign ws             = WAIT_STATES[{region, 2'b00} +: 4];
  assign mem_region     = region;
  assign mem_addr       = addr_q[23:0];
  assign unused_addr_hi = ^addr_q[ADDR_W-1:28];

  mem_lane_align u_lane (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata_raw (mem_rdata),
    .byte_en   (lane_be),
    .wdata_rep (mem_wdata),
    .rdata_out (rd_aligned)
  );

  // Unmapped reads and all writes return zero.
  assign rd_now = (!write_q && region != REGION_UNMAPPED) ? rd_aligned : 32'h0;
  // The bank word is only present during DONE, so rdata passes it through then and
  // holds the captured copy afterwards.
  assign rdata  = (state_q == ST_DONE) ? rd_now : rdata_q;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pause[i] = req_valid[i] & ~(state_q == ST_DONE && port_q == PTR_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    port_d   = port_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    write_d  = write_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    mem_en   = 1'b0;
    mem_we   = 4'h0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          port_d  = pick_idx;
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          size_d  = mem_size_t'(size_arr[pick_idx]);
          write_d = req_write[pick_idx];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (region == REGION_UNMAPPED) begin
          state_d = ST_DONE;
        end else begin
          mem_en  = 1'b1;
          // BIOS is read-only: the handshake completes but no lane is written.
          if (write_q && region != REGION_BIOS) mem_we = lane_be;
          wait_d  = ws;
          state_d = (ws == 4'd0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_en = 1'b1;
        if (wait_q == 4'd1) state_d = ST_DONE;
        else                wait_d  = wait_q - 4'd1;
      end
      ST_DONE: begin
        rdata_d  = rd_now;
        rr_ptr_d = (port_q == PTR_W'(NUM_PORTS - 1)) ? '0 : port_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      port_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SIZE_BYTE;
      write_q  <= 1'b0;
      wait_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      write_q  <= write_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  localparam int NP = 3;
`ifdef MEM_ARB_READ_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NP-1:0]   req_valid = '0;
  logic [NP*32-1:0] req_addr = '0;
  logic [NP*32-1:0] req_wdata = '0;
  logic [NP*2-1:0] req_size = '0;
  logic [NP-1:0]   req_write = '0;
  logic [NP-1:0]   pause;
  logic [31:0]     rdata;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [2:0]      mem_region;
  logic [23:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata = '0;

  mem_arbiter #(
    .NUM_PORTS   (NP),
    .WAIT_STATES (32'h0000_0200),
    .ADDR_W      (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_write  (req_write),
    .pause      (pause),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_region (mem_region),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bank model: synchronous read, data one cycle after mem_en; keyed by region code + word.
  logic [31:0] mem [logic [24:0]];
  always @(posedge clock) begin
    if (mem_en) begin
      logic [24:0] key;
      logic [31:0] w;
      key = {mem_region, mem_addr[23:2]};
      w = mem.exists(key) ? mem[key] : 32'h0;
      mem_rdata <= w;
      for (int b = 0; b < 4; b++) if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      mem[key] = w;
    end
  end

  typedef struct {
    int          port;
    logic [31:0] rdata;
    bit          chk_rd;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        if (req_valid[i] && !pause[i]) begin
          n_done++;
          if (sb_q.size() == 0) begin
            chk("sb_underflow", sb_q.size(), 1);
          end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("grant_port", i, e.port);
            if (e.chk_rd) chk("rdata", rdata, e.rdata);
          end
        end
      end
    end
  end

  logic [2:0]  first_region;
  logic [23:0] first_addr;

  task automatic issue(input int p, input logic [31:0] a, input logic [1:0] sz,
                       input logic wr, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input int exp_lat, input int exp_en, input logic [3:0] exp_we,
                       input logic [31:0] exp_wd);
    int lat;
    int en_cnt;
    logic [3:0]  we_or;
    logic [31:0] wd_cap;
    req_addr[32*p +: 32]  = a;
    req_wdata[32*p +: 32] = wd;
    req_size[2*p +: 2]    = sz;
    req_write[p]          = wr;
    sb_q.push_back('{port: p, rdata: exp_rd, chk_rd: !wr});
    req_valid[p] = 1'b1;
    lat = -1; en_cnt = 0; we_or = 4'h0; wd_cap = 32'h0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (mem_en) begin
        if (en_cnt == 0) begin
          first_region = mem_region;
          first_addr   = mem_addr;
        end
        en_cnt++;
      end
      if (mem_we != 4'h0) begin
        we_or  = we_or | mem_we;
        wd_cap = mem_wdata;
      end
      if (!pause[p]) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, exp_lat);
    chk("mem_en_cycles", en_cnt, exp_en);
    chk("mem_we", {28'h0, we_or}, {28'h0, exp_we});
    if (exp_we != 4'h0) chk("mem_wdata", wd_cap, exp_wd);
    @(posedge clock);
    #1;
    req_valid[p] = 1'b0;
  endtask

  initial begin
    mem[{3'd3, 22'h1}] = 32'hDEAD_BEEF;  // 0x0300_0004
    mem[{3'd6, 22'h0}] = 32'h1122_3344;  // 0x0600_0000
    mem[{3'd2, 22'h0}] = 32'h1234_5678;  // 0x0200_0000
    mem[{3'd0, 22'h4}] = 32'hE3A0_0000;  // 0x0000_0010

    // Reset with all ports requesting word reads.
    req_addr  = {32'h0600_0000, 32'h0200_0000, 32'h0300_0004};
    req_size  = {2'b10, 2'b10, 2'b10};
    req_write = '0;
    req_valid = '1;
    repeat (2) @(negedge clock);
    chk("reset_pause", {29'h0, pause}, 32'h7);
    chk("reset_mem_en", {31'h0, mem_en}, 32'h0);
    chk("reset_mem_we", {28'h0, mem_we}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);

    sb_q.push_back('{port: 0, rdata: 32'hDEAD_BEEF, chk_rd: 1'b1});
    sb_q.push_back('{port: 1, rdata: 32'h1234_5678, chk_rd: 1'b1});
    sb_q.push_back('{port: 2, rdata: 32'h1122_3344, chk_rd: 1'b1});
    sb_q.push_back('{port: 0, rdata: 32'hDEAD_BEEF, chk_rd: 1'b1});
    sb_q.push_back('{port: 1, rdata: 32'h1234_5678, chk_rd: 1'b1});
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 100 && n_done < 5; k++) begin
      @(negedge clock);
      #1;
    end
    chk("rr_completions", n_done, 5);
    @(posedge clock);
    #1;
    req_valid = '0;
    chk("rr_sb_drain", sb_q.size(), 0);

    // IWRAM word read, 0 wait states.
    issue(0, 32'h0300_0004, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 1, 4'h0, 32'h0);
    chk("iwram_region", {29'h0, first_region}, 32'h3);
    chk("iwram_offset", {8'h0, first_addr}, 32'h4);
    // Misaligned word read.
    issue(0, 32'h0300_0005, 2'b10, 1'b0, 32'h0,
          ALIGN ? 32'hEFDE_ADBE : 32'hDEAD_BEEF, 2, 1, 4'h0, 32'h0);
    // VRAM byte write then word readback.
    issue(1, 32'h0600_0003, 2'b00, 1'b1, 32'h0000_00A5, 32'h0, 2, 1, 4'b1000, 32'hA5A5_A5A5);
    issue(1, 32'h0600_0000, 2'b10, 1'b0, 32'h0, 32'hA522_3344, 2, 1, 4'h0, 32'h0);
    // EWRAM read with 2 wait states.
    issue(2, 32'h0200_0000, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 4, 3, 4'h0, 32'h0);
    // Unmapped read: no bank access, zero data.
    issue(0, 32'h0100_0000, 2'b10, 1'b0, 32'h0, 32'h0, 2, 0, 4'h0, 32'h0);
    // IWRAM half write to the upper half, then readbacks.
    issue(2, 32'h0300_0006, 2'b01, 1'b1, 32'h0000_CAFE, 32'h0, 2, 1, 4'b1100, 32'hCAFE_CAFE);
    issue(0, 32'h0300_0004, 2'b10, 1'b0, 32'h0, 32'hCAFE_BEEF, 2, 1, 4'h0, 32'h0);
    issue(1, 32'h0300_0007, 2'b00, 1'b0, 32'h0,
          ALIGN ? 32'h0000_00CA : 32'hCAFE_BEEF, 2, 1, 4'h0, 32'h0);
    issue(2, 32'h0300_0006, 2'b01, 1'b0, 32'h0,
          ALIGN ? 32'h0000_CAFE : 32'hCAFE_BEEF, 2, 1, 4'h0, 32'h0);
    // BIOS write is dropped but the handshake completes.
    issue(0, 32'h0000_0010, 2'b10, 1'b1, 32'h1234_5678, 32'h0, 2, 1, 4'h0, 32'h0);
    issue(0, 32'h0000_0010, 2'b10, 1'b0, 32'h0, 32'hE3A0_0000, 2, 1, 4'h0, 32'h0);
    // Word write with reserved size 11 uses all lanes.
    issue(1, 32'h0700_0008, 2'b11, 1'b1, 32'h0BAD_F00D, 32'h0, 2, 1, 4'hF, 32'h0BAD_F00D);
    issue(2, 32'h0700_0008, 2'b10, 1'b0, 32'h0, 32'h0BAD_F00D, 2, 1, 4'h0, 32'h0);

    repeat (2) @(negedge clock);
    chk("final_sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
